sha512_pad_2: RTL

Byte-serial message loader and padder that feeds the two-chunk SHA-512 compression core. It accepts a message one byte at a time over a valid/ready stream and applies SHA-512 padding across a fixed 256-byte, two-block frame. It presents the result as two 1024-bit chunks, held stable until the downstream controller acknowledges them. Frame layout is always two blocks, because the downstream core always processes both chunks.

---
 rtl/sha512_pad_2.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sha512_pad_2.sv
// Byte-serial SHA-512 message loader: gathers up to 239 bytes into a fixed
// two-block (256-byte) frame, appends the 0x80 marker and 128-bit bit length.
module sha512_pad_2 (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [1023:0] chunk0,
    output logic [1023:0] chunk1,
    output logic          out_valid,
    input  logic          out_ack,
    output logic          overflow,
    output logic          std_len
);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        FINAL  = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t       state_reg;
    logic [7:0]   count_reg;
    logic         overflow_reg;
    logic         std_len_reg;
    logic         out_valid_reg;
    logic         in_ready_reg;

    logic         hs;
    logic         wr_en;
    logic         fin;
    logic         clr;
    logic [127:0] len_field;

    // in_ready_reg is only ever 1 in ACCEPT, so it doubles as the state qualifier.
    assign hs        = in_valid && in_ready_reg;
    assign wr_en     = hs && (count_reg != 8'd239);
    assign fin       = (state_reg == FINAL);
    assign clr       = (state_reg == HOLD) && out_valid_reg && out_ack;
    assign len_field = {117'd0, count_reg, 3'b000};

    assign in_ready  = in_ready_reg && !reset;
    assign out_valid = out_valid_reg;
    assign overflow  = overflow_reg;
    assign std_len   = std_len_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ACCEPT;
            count_reg     <= 8'd0;
            overflow_reg  <= 1'b0;
            std_len_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ACCEPT: begin
                    if (hs) begin
                        if (count_reg != 8'd239)
                            count_reg <= count_reg + 8'd1;
                        else
                            overflow_reg <= 1'b1;
                        if (in_last) begin
                            state_reg    <= FINAL;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                FINAL: begin
                    std_len_reg <= (count_reg >= 8'd112) && !overflow_reg;
                    state_reg   <= HOLD;
                end
                HOLD: begin
                    // out_valid rises one cycle into HOLD; ack is honoured only after that.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                    end else if (out_ack) begin
                        count_reg     <= 8'd0;
                        overflow_reg  <= 1'b0;
                        std_len_reg   <= 1'b0;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ACCEPT;
                    end
                end
                default: begin
                    state_reg    <= ACCEPT;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_byte
            logic [7:0] byte_reg;

            if (gi < 240) begin : g_msg
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)
                        byte_reg <= 8'h00;
                    else if (clr)
                        byte_reg <= 8'h00;
                    else if (wr_en && (count_reg == 8'(gi)))
                        byte_reg <= in_data;
                    else if (fin && (count_reg == 8'(gi)))
                        byte_reg <= 8'h80;
                end
            end else begin : g_len
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)
                        byte_reg <= 8'h00;
                    else if (clr)
                        byte_reg <= 8'h00;
                    else if (fin)
                        byte_reg <= len_field[127-8*(gi-240) -: 8];
                end
            end

            if (gi < 128) begin : g_c0
                assign chunk0[1023-8*gi -: 8] = byte_reg;
            end else begin : g_c1
                assign chunk1[1023-8*(gi-128) -: 8] = byte_reg;
            end
        end
    endgenerate

endmodule
